awg_index_loader: RTL
=====================

Name: awg_index_loader

Overview:
Sequences the two-frame serial load of a 19-bit AWG sequencer index into the AWG's external serial interface.
- Frame HI: Data_Select=1, then idx[18:13], then a Load strobe.
- Frame LO: Data_Select=0, then idx[12:0], then a Load strobe.

Accepts one index per start/busy handshake, generates serial clock, data and load timing, and pulses done on completion. Sits between the sequence-control logic and the AWG connector pins.

Parameters:
CLK_DIV, 4, system clocks per serial-clock half period (D); legal range 1..255
IDX_W, 19, sequencer index width; fixed at 19, any other value is illegal
HI_W, 6, number of index bits sent in frame HI (idx[18:13])

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  request to load index; sampled only while busy=0
index  in  19  sequencer index, latched on the accepting edge
busy  out  1  high from the edge after accept until the done cycle
done  out  1  single-cycle completion pulse
ser_clk  out  1  AWG serial clock
ser_data  out  1  AWG serial data, MSB first
ser_load  out  1  AWG load strobe

Behaviour:
- Reset: asynchronous and active-high; clears all state.
  - Reset values: busy=0, done=0, ser_clk=0, ser_data=0, ser_load=0, FSM=IDLE, counters=0.
  - Reset mid-transfer aborts immediately. There is no partial Load, and the next transfer restarts at frame HI.
- FSM states: IDLE -> SHIFT_HI -> LOAD_HI -> SHIFT_LO -> LOAD_LO -> IDLE.
- Accept: the edge E0 where FSM=IDLE and start=1.
  - index is latched into a 19-bit holding register.
  - At E0 the FSM goes to SHIFT_HI and busy=1.
  - start while busy=1 is ignored; index changes after E0 have no effect.
- Bit slot: 2*D clocks.
  - ser_data is valid for the whole slot.
  - ser_clk=0 for the first D clocks and 1 for the last D clocks, so the AWG samples on the mid-slot rising edge.
- SHIFT_HI: 7 slots, carrying bits 1, idx[18], ..., idx[13].
- LOAD_HI: one 2*D slot with ser_load=1, ser_clk=0, ser_data=0.
- SHIFT_LO: 14 slots, carrying bits 0, idx[12], ..., idx[0].
- LOAD_LO: one 2*D slot with ser_load=1, ser_clk=0, ser_data=0.
- Completion: at the edge ending LOAD_LO, FSM=IDLE, busy=0 and done=1 for exactly 1 cycle.
  - Total busy time is 46*D clocks.
  - A start held high during the done cycle is accepted in that same cycle; back-to-back transfers have zero idle gap.
- Outside SHIFT and LOAD states: ser_clk=0, ser_data=0, ser_load=0.
- Counters:
  - A slot-phase counter of width clog2(2*D) wraps at 2*D-1.
  - A bit counter of 5 bits counts 0..13 and resets on every state change.
  - D=1 is legal: ser_clk toggles every clock.
- Outputs are registered, with no combinational path from inputs to ser_* outputs.

Optional Feature:
AWG_HI_CACHE_EN
- Defined:
  - A 6-bit register hi_cache plus a valid flag are updated with idx[18:13] at the end of each completed LOAD_HI.
  - On accept, if valid=1 and index[18:13]==hi_cache, the FSM goes directly to SHIFT_LO and busy time is 30*D.
  - rst clears the valid flag.
  - A reset mid-transfer also leaves the flag clear.
- Undefined: no cache logic; every transfer sends both frames (46*D).

Test Plan:
1. Reset, D=4, start with index=19'h5A5A5 -> frame HI ser_data sampled on ser_clk rising edges = 1,1,0,1,1,0,1. Then ser_load high for 8 clocks. Frame LO = 0,0,0,1,0,1,1,0,1,0,0,1,0,1. Then ser_load high for 8 clocks. done pulses 184 clocks after E0.
2. start held high continuously for 3 transfers with index 0, 19'h7FFFF, 0 -> exactly 3 done pulses, 552 clocks total with no gap. All-ones transfer yields 7 ones in HI and 0 followed by 13 ones in LO.
3. start pulsed again during busy with a different index -> ignored. The serial stream matches the first index and only one done pulse occurs.
4. Assert rst at clock 50 of a transfer -> all outputs 0 asynchronously and no ser_load pulse. A new start after release produces a full 46*D transfer.
5. D=1, index=19'h00001 -> ser_clk toggles every clock, done at 46 clocks, and the last LO bit is 1.
6. With AWG_HI_CACHE_EN defined: load 19'h5A5A5, then 19'h5A000 -> the second transfer has no HI frame and busy lasts 120 clocks. A third load of 19'h00000 sends the HI frame again (184 clocks). After rst, 19'h00000 again sends HI.

Source files
------------

// File: rtl/awg_index_loader.sv
// Two-frame serial loader for the 19-bit AWG sequencer index (HI frame, then LO frame).
// Optional macro AWG_HI_CACHE_EN: skip the HI frame when idx[18:13] matches the last one loaded.
`timescale 1ns/1ps
module awg_index_loader #(
    parameter int CLK_DIV = 4,
    parameter int IDX_W   = 19,
    parameter int HI_W    = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [IDX_W-1:0] index,
    output logic             busy,
    output logic             done,
    output logic             ser_clk,
    output logic             ser_data,
    output logic             ser_load
);

    localparam int LO_W = IDX_W - HI_W;
    localparam int PH_W = $clog2(2 * CLK_DIV);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * CLK_DIV - 1);
    localparam logic [PH_W-1:0] PH_HALF = PH_W'(CLK_DIV);
    localparam logic [4:0]      HI_LAST = 5'(HI_W);
    localparam logic [4:0]      LO_LAST = 5'(LO_W);

    generate
        if (IDX_W != 19 || HI_W != 6 || CLK_DIV < 1 || CLK_DIV > 255) begin : g_bad_param
            $error("awg_index_loader: illegal parameter set");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_HI,
        LOAD_HI,
        SHIFT_LO,
        LOAD_LO
    } state_t;

    state_t           state, state_n;
    logic [PH_W-1:0]  phase, phase_n;
    logic [4:0]       bit_cnt, bit_n, last_bit;
    logic [IDX_W-1:0] idx_q, idx_n;
    logic             busy_n, done_n, clk_n, data_n, load_n;
    logic             slot_end, frame_end, shifting, cache_hit;

    assign slot_end  = (phase == PH_LAST);
    assign frame_end = slot_end && (bit_cnt == last_bit);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        last_bit = 5'd0;
        case (state)
            SHIFT_HI: last_bit = HI_LAST;
            SHIFT_LO: last_bit = LO_LAST;
            default:  last_bit = 5'd0;
        endcase
    end

    // idx_q rotates left once per data bit, so its MSB is always the next bit to send;
    // after HI its low HI_W bits hold idx[18:13], and after LO it is back in order.
    always_comb begin
        state_n = state;
        phase_n = phase;
        bit_n   = bit_cnt;
        idx_n   = idx_q;
        done_n  = 1'b0;
        if (state == IDLE) begin
            if (start) begin
                phase_n = '0;
                bit_n   = 5'd0;
                if (cache_hit) begin
                    state_n = SHIFT_LO;
                    idx_n   = {index[LO_W-1:0], index[IDX_W-1 -: HI_W]};
                end else begin
                    state_n = SHIFT_HI;
                    idx_n   = index;
                end
            end
        end else if (!slot_end) begin
            phase_n = phase + 1'b1;
        end else begin
            phase_n = '0;
            if ((state == SHIFT_HI || state == SHIFT_LO) && bit_cnt != 5'd0)
                idx_n = {idx_q[IDX_W-2:0], idx_q[IDX_W-1]};
            if (bit_cnt == last_bit) begin
                bit_n = 5'd0;
                case (state)
                    SHIFT_HI: state_n = LOAD_HI;
                    LOAD_HI:  state_n = SHIFT_LO;
                    SHIFT_LO: state_n = LOAD_LO;
                    default: begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                endcase
            end else begin
                bit_n = bit_cnt + 5'd1;
            end
        end

        // Serial outputs are derived from the next state so they register in step with it.
        shifting = (state_n == SHIFT_HI) || (state_n == SHIFT_LO);
        busy_n   = (state_n != IDLE);
        clk_n    = shifting && (phase_n >= PH_HALF);
        data_n   = shifting && ((bit_n == 5'd0) ? (state_n == SHIFT_HI) : idx_n[IDX_W-1]);
        load_n   = (state_n == LOAD_HI) || (state_n == LOAD_LO);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            phase    <= '0;
            bit_cnt  <= 5'd0;
            idx_q    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ser_clk  <= 1'b0;
            ser_data <= 1'b0;
            ser_load <= 1'b0;
        end else begin
            state    <= state_n;
            phase    <= phase_n;
            bit_cnt  <= bit_n;
            idx_q    <= idx_n;
            busy     <= busy_n;
            done     <= done_n;
            ser_clk  <= clk_n;
            ser_data <= data_n;
            ser_load <= load_n;
        end
    end

`ifdef AWG_HI_CACHE_EN
    logic [HI_W-1:0] hi_cache;
    logic            hi_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_cache <= '0;
            hi_valid <= 1'b0;
        end else if (state == LOAD_HI && frame_end) begin
            hi_cache <= idx_q[HI_W-1:0];
            hi_valid <= 1'b1;
        end
    end

    assign cache_hit = hi_valid && (index[IDX_W-1 -: HI_W] == hi_cache);
`else
    assign cache_hit = 1'b0;
`endif

endmodule
